mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style control FSM: sequences fetch, decode, memory, ALU and writeback datapath strobes.
// Optional build macro JAL_EN adds the JAL state (code 12) for opcode 000011.
module mc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [3:0] state,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       alu_src_a,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       L_S
);

   localparam logic [3:0] S_IF    = 4'd0;
   localparam logic [3:0] S_ID    = 4'd1;
   localparam logic [3:0] S_MADDR = 4'd2;
   localparam logic [3:0] S_MRD   = 4'd3;
   localparam logic [3:0] S_LWB   = 4'd4;
   localparam logic [3:0] S_MWR   = 4'd5;
   localparam logic [3:0] S_REX   = 4'd6;
   localparam logic [3:0] S_RWB   = 4'd7;
   localparam logic [3:0] S_BEQ   = 4'd8;
   localparam logic [3:0] S_JMP   = 4'd9;
   localparam logic [3:0] S_IEX   = 4'd10;
   localparam logic [3:0] S_IWB   = 4'd11;
`ifdef JAL_EN
   localparam logic [3:0] S_JAL   = 4'd12;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic [3:0] next_state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IF;
      else     state <= next_state;
   end

   // NOTE: every output gets a default first, so no path through the case infers a latch.
   always_comb begin
      next_state    = S_IF;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      alu_src_a     = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      L_S           = 1'b0;

      // Reset masks every strobe, including the fetch read that IF would otherwise assert.
      if (!rst) begin
         case (state)
            S_IF: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  next_state = S_ID;
               end else begin
                  next_state = S_IF;
               end
            end
            S_ID: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_RTYPE:                         next_state = S_REX;
                  OP_LW, OP_SW:                     next_state = S_MADDR;
                  OP_BEQ:                           next_state = S_BEQ;
                  OP_J:                             next_state = S_JMP;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IEX;
`ifdef JAL_EN
                  OP_JAL:                           next_state = S_JAL;
`endif
                  default:                          next_state = S_IF;
               endcase
            end
            S_MADDR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               next_state = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
               mem_read   = 1'b1;
               i_or_d     = 1'b1;
               next_state = mem_ready ? S_LWB : S_MRD;
            end
            S_MWR: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               next_state = mem_ready ? S_IF : S_MWR;
            end
            S_LWB: begin
               L_S        = 1'b1;
               mem_to_reg = 2'b01;
            end
            S_REX: begin
               alu_src_a  = 1'b1;
               alu_op     = 2'b10;
               next_state = S_RWB;
            end
            S_RWB: begin
               L_S     = 1'b1;
               reg_dst = 2'b01;
            end
            S_BEQ: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            S_JMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_IEX: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               alu_op     = 2'b11;
               next_state = S_IWB;
            end
            S_IWB: begin
               L_S = 1'b1;
            end
`ifdef JAL_EN
            S_JAL: begin
               L_S        = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
               pc_write   = 1'b1;
               pc_source  = 2'b10;
            end
`endif
            default: next_state = S_IF;
         endcase
      end
   end

   // opcode is only partially decoded for JAL when JAL_EN is off; keep the constant referenced.
   logic unused_jal;
   assign unused_jal = (OP_JAL == 6'b000011);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table-driven cycle vectors plus hand-written asynchronous-reset sequences.
module tb_mc_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [3:0] state;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
   logic       L_S;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .state(state),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .L_S(L_S)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle: {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
   //          reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, L_S}
   logic [17:0] act_out;
   assign act_out = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
                     reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, L_S};

   localparam logic [17:0] O_ZERO    = 18'd0;
   localparam logic [17:0] O_IF_WAIT = {7'b0001000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_IF_GO   = {7'b1011000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_ID      = {7'b0000000, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_MADDR   = {7'b0000001, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_MRD     = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_MWR     = {7'b0000110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [17:0] O_LWB     = {7'b0000000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
   localparam logic [17:0] O_REX     = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [17:0] O_RWB     = {7'b0000000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
   localparam logic [17:0] O_BEQ     = {7'b0100001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0};
   localparam logic [17:0] O_JMP     = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0};
   localparam logic [17:0] O_IEX     = {7'b0000001, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0};
   localparam logic [17:0] O_IWB     = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
`ifdef JAL_EN
   localparam logic [17:0] O_JAL     = {7'b1000000, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1};
`endif

   typedef struct {
      string       name;
      logic        rst;
      logic        mem_ready;
      logic [5:0]  opcode;
      logic [3:0]  exp_state;
      logic [17:0] exp_out;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic add(input string name, input logic r, input logic mr, input logic [5:0] op,
                      input logic [3:0] st, input logic [17:0] o);
      vec_t v;
      v.name = name; v.rst = r; v.mem_ready = mr; v.opcode = op; v.exp_state = st; v.exp_out = o;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_cycle(input string name, input logic [3:0] st, input logic [17:0] o);
      check({name, ".state"}, {28'd0, state}, {28'd0, st});
      check({name, ".outs"}, {14'd0, act_out}, {14'd0, o});
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;

      // Each row: inputs held for one cycle, expected state/outputs sampled before the next edge.
      add("reset",     1, 1, 6'b000000, 4'd0,  O_ZERO);
      add("r.if",      0, 1, 6'b000000, 4'd0,  O_IF_GO);
      add("r.id",      0, 1, 6'b000000, 4'd1,  O_ID);
      add("r.rex",     0, 1, 6'b000000, 4'd6,  O_REX);
      add("r.rwb",     0, 1, 6'b000000, 4'd7,  O_RWB);
      add("lw.if",     0, 1, 6'b100011, 4'd0,  O_IF_GO);
      add("lw.id",     0, 1, 6'b100011, 4'd1,  O_ID);
      add("lw.maddr",  0, 1, 6'b100011, 4'd2,  O_MADDR);
      add("lw.mrd0",   0, 0, 6'b100011, 4'd3,  O_MRD);
      add("lw.mrd1",   0, 0, 6'b100011, 4'd3,  O_MRD);
      add("lw.mrd2",   0, 1, 6'b100011, 4'd3,  O_MRD);
      add("lw.lwb",    0, 1, 6'b100011, 4'd4,  O_LWB);
      add("sw.ifw0",   0, 0, 6'b101011, 4'd0,  O_IF_WAIT);
      add("sw.ifw1",   0, 0, 6'b101011, 4'd0,  O_IF_WAIT);
      add("sw.ifw2",   0, 0, 6'b101011, 4'd0,  O_IF_WAIT);
      add("sw.if",     0, 1, 6'b101011, 4'd0,  O_IF_GO);
      add("sw.id",     0, 1, 6'b101011, 4'd1,  O_ID);
      add("sw.maddr",  0, 1, 6'b101011, 4'd2,  O_MADDR);
      add("sw.mwr0",   0, 0, 6'b101011, 4'd5,  O_MWR);
      add("sw.mwr1",   0, 1, 6'b101011, 4'd5,  O_MWR);
      add("beq.if",    0, 1, 6'b000100, 4'd0,  O_IF_GO);
      add("beq.id",    0, 1, 6'b000100, 4'd1,  O_ID);
      add("beq.ex",    0, 1, 6'b000100, 4'd8,  O_BEQ);
      add("j.if",      0, 1, 6'b000010, 4'd0,  O_IF_GO);
      add("j.id",      0, 1, 6'b000010, 4'd1,  O_ID);
      add("j.jmp",     0, 1, 6'b000010, 4'd9,  O_JMP);
      add("addi.if",   0, 1, 6'b001000, 4'd0,  O_IF_GO);
      add("addi.id",   0, 1, 6'b001000, 4'd1,  O_ID);
      add("addi.iex",  0, 1, 6'b001000, 4'd10, O_IEX);
      add("addi.iwb",  0, 1, 6'b001000, 4'd11, O_IWB);
      add("slti.if",   0, 1, 6'b001010, 4'd0,  O_IF_GO);
      add("slti.id",   0, 1, 6'b001010, 4'd1,  O_ID);
      add("slti.iex",  0, 1, 6'b001010, 4'd10, O_IEX);
      add("slti.iwb",  0, 1, 6'b001010, 4'd11, O_IWB);
      add("ill.if",    0, 1, 6'b111111, 4'd0,  O_IF_GO);
      add("ill.id",    0, 1, 6'b111111, 4'd1,  O_ID);
      add("jal.if",    0, 1, 6'b000011, 4'd0,  O_IF_GO);
      add("jal.id",    0, 1, 6'b000011, 4'd1,  O_ID);
`ifdef JAL_EN
      add("jal.jal",   0, 1, 6'b000011, 4'd12, O_JAL);
`endif
      add("end.if",    0, 0, 6'b000000, 4'd0,  O_IF_WAIT);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].rst; mem_ready = vecs[i].mem_ready; opcode = vecs[i].opcode;
         #1;
         check_cycle(vecs[i].name, vecs[i].exp_state, vecs[i].exp_out);
      end

      // Asynchronous reset pulse while in RWB, entirely between clock edges.
      @(negedge clk); rst = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;  // IF
      @(negedge clk);                                                    // ID
      @(negedge clk);                                                    // REX
      @(negedge clk); #1;
      check_cycle("arst.pre_rwb", 4'd7, O_RWB);
      rst = 1'b1; #1;
      check_cycle("arst.during", 4'd0, O_ZERO);
      #1 rst = 1'b0; #1;
      check_cycle("arst.released", 4'd0, O_IF_GO);
      @(negedge clk); #1;
      check_cycle("arst.first_fetch", 4'd1, O_ID);

      // Reset held across an edge during a stalled store: no write strobe may survive.
      opcode = 6'b101011;
      @(negedge clk);                 // MADDR
      @(negedge clk); mem_ready = 1'b0; #1;
      check_cycle("abort.mwr", 4'd5, O_MWR);
      rst = 1'b1;
      @(negedge clk); #1;
      check_cycle("abort.held", 4'd0, O_ZERO);
      rst = 1'b0; mem_ready = 1'b1; #1;
      check_cycle("abort.released", 4'd0, O_IF_GO);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
